fifo_wm: RTL and testbench
==========================

FIFO_WM -- requirements
Module: fifo_wm

Interface

REQ-001 Parameter DATA_W, default 10: width of each FIFO entry.
REQ-002 Parameter ADDR_W, default 3: address width; depth = 2**ADDR_W (8 by default).
REQ-003 Parameter HIGH_WM, default 6: occupancy at or above which pause asserts.
REQ-004 Parameter LOW_WM, default 2: occupancy at or below which a paused FIFO signals continue; LOW_WM < HIGH_WM <= depth.
REQ-005 Clock and reset: one clock; reset is asynchronous and active-high.
REQ-006 clk  input  1  sole clock; all state updates on its rising edge.
REQ-007 reset  input  1  asynchronous, active-high reset.
REQ-008 push  input  1  write request for data_in this cycle.
REQ-009 data_in  input  DATA_W  write data.
REQ-010 pop  input  1  read request for the head entry.
REQ-011 data_out  output  DATA_W  registered read data.
REQ-012 valid_out  output  1  data_out carries a newly popped entry this cycle.
REQ-013 empty  output  1  occupancy == 0.
REQ-014 full  output  1  occupancy == depth.
REQ-015 pause  output  1  flow-control pause level toward the arbitration FSM.
REQ-016 continue  output  1  one-cycle pulse toward the arbitration FSM: resume after pause.
REQ-017 error_full  output  1  sticky flag: a push was attempted while full.
REQ-018 count  output  ADDR_W+1  current occupancy.
REQ-019 err_cnt  output  8  number of dropped pushes; only meaningful when the macro in REQ-034 is defined.

Function

REQ-020 Accepted push: push=1 and full=0, or push=1 and full=1 with an accepted pop in the same cycle. An accepted push writes data_in at the write pointer and advances the pointer modulo depth.
REQ-021 Accepted pop: pop=1 and empty=0. An accepted pop loads the head entry into data_out on the next edge with valid_out=1 for one cycle, then advances the read pointer modulo depth.
REQ-022 Read latency is exactly 1 cycle. With no accepted pop, valid_out=0 and data_out holds its last value.
REQ-023 Push and pop accepted together: count unchanged, both pointers advance. On empty, only the push is accepted (no fall-through).
REQ-024 Push while full with no pop: the write is dropped, count is unchanged, and error_full is set on the next edge.
REQ-025 Pop while empty: ignored; valid_out=0; no error.
REQ-026 empty, full and count reflect the registered occupancy after each edge.
REQ-027 Flow-control FSM has two states, FLOW and PAUSED; pause=1 exactly in PAUSED.
REQ-028 FLOW -> PAUSED on the edge where the updated count >= HIGH_WM.
REQ-029 PAUSED -> FLOW on the edge where the updated count <= LOW_WM; continue=1 for exactly that one cycle.
REQ-030 In FLOW, continue=0; passing through LOW_WM without a prior pause generates no pulse.
REQ-031 count between LOW_WM and HIGH_WM leaves the state unchanged (hysteresis).

Reset

REQ-032 When reset asserts, immediately and regardless of clk: pointers=0, count=0, empty=1, full=0, data_out=0, valid_out=0, state=FLOW, pause=0, continue=0, error_full=0, err_cnt=0.
REQ-033 Reset mid-operation discards all contents; push and pop are ignored while reset=1.

Configuration

REQ-034 Macro FIFO_WM_ERR_CNT_EN defined: err_cnt increments by 1 per dropped push (REQ-024) and saturates at 255.
REQ-035 Macro FIFO_WM_ERR_CNT_EN undefined: err_cnt is tied to 0 and no counter logic is built; all other behaviour is identical.

Verification

REQ-036 Push 0x001..0x003, then pop 3 times -> data_out 0x001, 0x002, 0x003, each 1 cycle after its pop, valid_out=1 each time; empty=1 afterward.
REQ-037 Push 6 entries with no pop -> pause=1 on the edge where count becomes 6. Pop 4 -> continue pulses 1 cycle on the edge where count becomes 2, and pause=0 from that edge.
REQ-038 Fill to 8, push once more with no pop -> count stays 8, full=1, error_full=1. With the macro defined, err_cnt=1; 300 such pushes give err_cnt=255.
REQ-039 At count=8, push and pop in the same cycle -> count stays 8, error_full stays 0, popped entry is the oldest, new entry is stored.
REQ-040 Pop at empty -> valid_out=0 and count=0. Assert reset asynchronously mid-burst at count=5 with pause=0 -> all outputs take REQ-032 values before the next clk edge.
REQ-041 Perform 20 push/pop pairs across pointer wrap-around -> data order preserved, count constant, no continue pulse.

Source files
------------

// File: rtl/fifo_wm.sv
// Synchronous FIFO with registered read port and hysteresis pause/continue flow control.
// Optional dropped-push counter built only when FIFO_WM_ERR_CNT_EN is defined.
module fifo_wm #(
  parameter int DATA_W  = 10,
  parameter int ADDR_W  = 3,
  parameter int HIGH_WM = 6,
  parameter int LOW_WM  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] data_in,
  input  logic              pop,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  output logic              empty,
  output logic              full,
  output logic              pause,
  output logic              continue_pulse,
  output logic              error_full,
  output logic [ADDR_W:0]   count,
  output logic [7:0]        err_cnt
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   HIGH_C  = (ADDR_W+1)'(HIGH_WM);
  localparam logic [ADDR_W:0]   LOW_C   = (ADDR_W+1)'(LOW_WM);
  localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

  typedef enum logic {FLOW, PAUSED} state_t;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [ADDR_W:0]   count_nxt;
  logic              pop_ok, push_ok, drop;
  state_t            state, state_nxt;
  logic              cont_nxt;

  assign empty   = (count == '0);
  assign full    = (count == DEPTH_C);
  assign pop_ok  = pop & ~empty;
  // A pop in the same cycle frees the slot, so a push at full is still accepted.
  assign push_ok = push & (~full | pop_ok);
  assign drop    = push & full & ~pop_ok;
  assign pause   = (state == PAUSED);

  always_comb begin
    count_nxt = count;
    if (push_ok && !pop_ok)
      count_nxt = count + CNT_ONE;
    else if (pop_ok && !push_ok)
      count_nxt = count - CNT_ONE;
  end

  always_comb begin
    state_nxt = state;
    cont_nxt  = 1'b0;
    case (state)
      FLOW:   if (count_nxt >= HIGH_C) state_nxt = PAUSED;
      PAUSED: if (count_nxt <= LOW_C) begin
                state_nxt = FLOW;
                cont_nxt  = 1'b1;
              end
      default: state_nxt = FLOW;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= FLOW;
      continue_pulse <= 1'b0;
    end else begin
      state          <= state_nxt;
      continue_pulse <= cont_nxt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      data_out   <= '0;
      valid_out  <= 1'b0;
      error_full <= 1'b0;
    end else begin
      if (push_ok)
        wr_ptr <= wr_ptr + PTR_ONE;
      if (pop_ok) begin
        data_out <= mem[rd_ptr];
        rd_ptr   <= rd_ptr + PTR_ONE;
      end
      valid_out <= pop_ok;
      count     <= count_nxt;
      if (drop)
        error_full <= 1'b1;
    end
  end

  // Storage is not reset; contents are unreachable once the pointers clear.
  always_ff @(posedge clk) begin
    if (push_ok && !reset)
      mem[wr_ptr] <= data_in;
  end

`ifdef FIFO_WM_ERR_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      err_cnt <= '0;
    else if (drop && err_cnt != 8'hFF)
      err_cnt <= err_cnt + 8'd1;
  end
`else
  assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_fifo_wm.sv
// Scoreboard bench for fifo_wm: reference queue model, expected pops queued at issue, compared at output.
module tb_fifo_wm;

  logic       clk = 1'b0;
  logic       reset, push, pop;
  logic [9:0] data_in;
  logic [9:0] data_out;
  logic       valid_out, empty, full, pause, continue_pulse, error_full;
  logic [3:0] count;
  logic [7:0] err_cnt;

  fifo_wm dut (
    .clk(clk), .reset(reset), .push(push), .data_in(data_in), .pop(pop),
    .data_out(data_out), .valid_out(valid_out), .empty(empty), .full(full),
    .pause(pause), .continue_pulse(continue_pulse), .error_full(error_full),
    .count(count), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  logic [9:0] m_q[$];
  logic [9:0] sb[$];
  bit         m_pause, m_cont, m_err;
  int         m_errcnt;
  logic [9:0] m_dout;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    m_q.delete();
    sb.delete();
    m_pause  = 0;
    m_cont   = 0;
    m_err    = 0;
    m_errcnt = 0;
    m_dout   = '0;
  endtask

  task automatic check_flags();
    int exp_ec;
`ifdef FIFO_WM_ERR_CNT_EN
    exp_ec = m_errcnt;
`else
    exp_ec = 0;
`endif
    check("count", count, m_q.size());
    check("empty", empty, m_q.size() == 0);
    check("full", full, m_q.size() == 8);
    check("pause", pause, m_pause);
    check("continue", continue_pulse, m_cont);
    check("error_full", error_full, m_err);
    check("err_cnt", err_cnt, exp_ec);
  endtask

  task automatic step(input bit p, input logic [9:0] d, input bit q);
    bit pop_ok, push_ok;
    logic [9:0] e;
    @(negedge clk);
    push = p; data_in = d; pop = q;
    pop_ok  = q && (m_q.size() != 0);
    push_ok = p && (m_q.size() < 8 || pop_ok);
    if (pop_ok) sb.push_back(m_q.pop_front());
    if (push_ok) m_q.push_back(d);
    if (p && !push_ok) begin
      m_err = 1;
      if (m_errcnt < 255) m_errcnt++;
    end
    m_cont = 0;
    if (!m_pause && m_q.size() >= 6) m_pause = 1;
    else if (m_pause && m_q.size() <= 2) begin
      m_pause = 0;
      m_cont  = 1;
    end
    @(posedge clk);
    #1;
    check("valid_out", valid_out, pop_ok);
    if (pop_ok) begin
      e = sb.pop_front();
      m_dout = e;
      check("data_out", data_out, e);
    end else begin
      check("data_hold", data_out, m_dout);
    end
    check_flags();
  endtask

  task automatic check_reset_outputs();
    check("rst_valid", valid_out, 0);
    check("rst_dout", data_out, 0);
    check_flags();
  endtask

  // Reset asserted between clock edges; outputs must clear without a clock edge.
  task automatic async_reset();
    @(negedge clk);
    #2;
    reset = 1;
    model_reset();
    #1;
    check_reset_outputs();
    push = 1; pop = 1; data_in = 10'h3AA;
    @(posedge clk);
    #1;
    check_reset_outputs();
    @(negedge clk);
    reset = 0; push = 0; pop = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1; push = 0; pop = 0; data_in = '0;
    model_reset();
    #12;
    check_reset_outputs();
    @(negedge clk);
    reset = 0;

    for (int i = 1; i <= 3; i++) step(1, 10'(i), 0);
    for (int i = 0; i < 3; i++) step(0, '0, 1);

    for (int i = 0; i < 6; i++) step(1, 10'(10'h040 + i), 0);
    for (int i = 0; i < 6; i++) step(0, '0, 1);

    step(0, '0, 1);
    step(0, '0, 1);

    for (int i = 0; i < 8; i++) step(1, 10'(10'h100 + i), 0);
    step(1, 10'h2F0, 1);
    step(1, 10'h2F1, 1);
    step(1, 10'h3FF, 0);
    for (int i = 0; i < 300; i++) step(1, 10'(i), 0);
    for (int i = 0; i < 8; i++) step(0, '0, 1);

    async_reset();
    for (int i = 0; i < 5; i++) step(1, 10'(10'h1A0 + i), 0);
    async_reset();

    for (int i = 0; i < 3; i++) step(1, 10'(10'h0C0 + i), 0);
    for (int i = 0; i < 20; i++) step(1, 10'($urandom_range(0, 1023)), 1);

    for (int i = 0; i < 300; i++)
      step(bit'($urandom_range(0, 99) < 55), 10'($urandom_range(0, 1023)),
           bit'($urandom_range(0, 99) < 45));
    for (int i = 0; i < 10; i++) step(0, '0, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
